// File: rtl/npc_predict_pkg.sv
// Shared encodings for the next-PC predictor: NPCOp codes, 2-bit counter states
// and the BTB write-control payload.
package npc_predict_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JALR   = 3'b100
  } npc_op_e;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_e;

  typedef struct packed {
    logic en;
    logic is_branch;
    logic taken;
  } btb_wr_t;

  // Saturating counter step toward the resolved direction.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken && (c != STRONG_T))
      n = ctr_e'(2'(c + 2'd1));
    else if (!taken && (c != STRONG_NT))
      n = ctr_e'(2'(c - 2'd1));
    return n;
  endfunction

endpackage

// File: rtl/npc_predict_if.sv
// Pipeline-facing bundle of the predictor: IF fetch outputs, EX resolution inputs.
interface npc_predict_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             stall;
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic [XLEN-1:0]  if_pred_target;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [2:0]       ex_npcop;
  logic             ex_zero;
  logic [XLEN-1:0]  ex_pc_imm;
  logic [XLEN-1:0]  ex_rs1_imm;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             flush;
  logic [CNT_W-1:0] mispredict_cnt;

  // Pipeline side
  modport master (
    output stall, ex_valid, ex_pc, ex_npcop, ex_zero, ex_pc_imm, ex_rs1_imm,
           ex_pred_taken, ex_pred_target,
    input  if_pc, if_pred_taken, if_pred_target, flush, mispredict_cnt
  );

  // Predictor side
  modport slave (
    input  stall, ex_valid, ex_pc, ex_npcop, ex_zero, ex_pc_imm, ex_rs1_imm,
           ex_pred_taken, ex_pred_target,
    output if_pc, if_pred_taken, if_pred_target, flush, mispredict_cnt
  );
endinterface

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational lookup,
// one synchronous write port that trains or allocates entries.
module npc_btb
  import npc_predict_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:2] rd_pc,
  output logic            rd_hit,
  output logic            rd_is_jump,
  output ctr_e            rd_ctr,
  output logic [XLEN-1:0] rd_target,
  input  btb_wr_t         wr,
  input  logic [XLEN-1:2] wr_pc,
  input  logic [XLEN-1:0] wr_target
);
  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [BTB_DEPTH-1:0] jump_q;
  logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
  logic [XLEN-1:0]      target_q [BTB_DEPTH];
  ctr_e                 ctr_q    [BTB_DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[XLEN-1:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[XLEN-1:IDX_W+2];

  // Lookup reads the registered contents, so a same-cycle write shows next cycle.
  assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_is_jump = jump_q[rd_idx];
  assign rd_ctr     = ctr_q[rd_idx];
  assign rd_target  = target_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WEAK_NT;
      end
    end else if (wr.en) begin
      if (wr_hit) begin
        if (wr.is_branch) begin
          ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr.taken);
        end else begin
          target_q[wr_idx] <= wr_target;
          ctr_q[wr_idx]    <= STRONG_T;
          jump_q[wr_idx]   <= 1'b1;
        end
      end else if (wr.taken) begin
        // Miss on a taken transfer: allocate, evicting any aliasing entry.
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
        jump_q[wr_idx]   <= !wr.is_branch;
        ctr_q[wr_idx]    <= wr.is_branch ? WEAK_T : STRONG_T;
      end
    end
  end

endmodule

// File: rtl/npc_predict.sv
// Fetch PC register with BTB-based next-PC prediction, EX-stage resolution,
// mispredict flush and a saturating mispredict counter.
module npc_predict
  import npc_predict_pkg::*;
#(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    CNT_W     = 16,
  parameter bit             PRED_EN   = 1'b1
) (
  input logic         clk,
  input logic         rstn,
  npc_predict_if.slave bus
);
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_plus4;
  logic [CNT_W-1:0] cnt_q;

  logic             bt_hit;
  logic             bt_is_jump;
  ctr_e             bt_ctr;
  logic [XLEN-1:0]  bt_target;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  npc_op_e          op;
  logic             is_ctrl;
  logic             act_taken;
  logic [XLEN-1:0]  act_target;
  logic [XLEN-1:0]  jalr_target;
  logic             mispredict;
  btb_wr_t          wr;

  npc_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk        (clk),
    .rstn       (rstn),
    .rd_pc      (pc_q[XLEN-1:2]),
    .rd_hit     (bt_hit),
    .rd_is_jump (bt_is_jump),
    .rd_ctr     (bt_ctr),
    .rd_target  (bt_target),
    .wr         (wr),
    .wr_pc      (bus.ex_pc[XLEN-1:2]),
    .wr_target  (act_target)
  );

  // IF-side prediction
  assign pc_plus4    = pc_q + XLEN'(4);
  assign pred_taken  = PRED_EN && bt_hit && (bt_is_jump || bt_ctr[1]);
  assign pred_target = pred_taken ? bt_target : pc_plus4;

  // EX-side resolution; JALR targets drop bit 0
  assign op          = npc_op_e'(bus.ex_npcop);
  assign jalr_target = bus.ex_rs1_imm & ~XLEN'(1);

  always_comb begin
    is_ctrl    = 1'b0;
    act_taken  = 1'b0;
    act_target = bus.ex_pc_imm;
    case (op)
      NPC_BRANCH: begin
        is_ctrl   = 1'b1;
        act_taken = bus.ex_zero;
      end
      NPC_JUMP: begin
        is_ctrl   = 1'b1;
        act_taken = 1'b1;
      end
      NPC_JALR: begin
        is_ctrl    = 1'b1;
        act_taken  = 1'b1;
        act_target = jalr_target;
      end
      default: ;
    endcase
  end

  assign mispredict = bus.ex_valid &&
                      ((act_taken != bus.ex_pred_taken) ||
                       (act_taken && bus.ex_pred_taken && (act_target != bus.ex_pred_target)));

  assign wr.en        = PRED_EN && bus.ex_valid && is_ctrl;
  assign wr.is_branch = (op == NPC_BRANCH);
  assign wr.taken     = act_taken;

  // Redirect on mispredict wins over a hazard stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
    end else if (mispredict) begin
      pc_q <= act_taken ? act_target : (bus.ex_pc + XLEN'(4));
    end else if (!bus.stall) begin
      pc_q <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (mispredict && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.if_pc          = pc_q;
  assign bus.if_pred_taken  = pred_taken;
  assign bus.if_pred_target = pred_target;
  assign bus.flush          = mispredict;
  assign bus.mispredict_cnt = cnt_q;

endmodule

// File: doc/npc_predict.md
Name: npc_predict

Overview:
- Parametrised successor to the combinational next-PC selector.
- Owns the fetch PC register and predicts the next fetch address with a direct-mapped BTB plus 2-bit saturating counters.
- Resolves control flow at EX using the existing NPCOp/Zero encoding and raises flush on any mispredict.
- Sits between IF (drives if_pc) and EX (resolution inputs); the pipeline carries the prediction from IF to EX.

Parameters:
XLEN, 32, address/data width
BTB_DEPTH, 16, BTB entries; power of 2, at least 2; IDX_W = log2(BTB_DEPTH)
RESET_PC, 32'h0000_0000, PC value after reset
CNT_W, 16, width of the mispredict statistics counter
PRED_EN, 1, 1 = use the BTB; 0 = always predict not-taken (plain pc+4 behaviour)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
stall  in  1  hold PC (hazard unit)
if_pc  out  XLEN  current fetch PC
if_pred_taken  out  1  prediction for if_pc
if_pred_target  out  XLEN  predicted next PC (if_pc+4 when not taken)
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_pc  in  XLEN  PC of the EX instruction
ex_npcop  in  3  NPC_PLUS4/BRANCH/JUMP/JALR encoding
ex_zero  in  1  branch condition from the ALU
ex_pc_imm  in  XLEN  pc+imm target
ex_rs1_imm  in  XLEN  rs1+imm target (JALR)
ex_pred_taken  in  1  prediction carried from IF
ex_pred_target  in  XLEN  predicted target carried from IF
flush  out  1  mispredict: squash IF/ID, redirect PC
mispredict_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, rstn=0): if_pc=RESET_PC; all BTB valid bits=0; counters=2'b01; mispredict_cnt=0. Outputs follow combinationally from this state: flush=0, if_pred_taken=0, if_pred_target=RESET_PC+4.
- Lookup (combinational from if_pc):
  - idx = if_pc[IDX_W+1:2]; tag = if_pc[XLEN-1:IDX_W+2].
  - hit = valid[idx] and tag match.
  - if_pred_taken = PRED_EN and hit and (entry.is_jump or ctr[idx][1]).
  - if_pred_target = entry target when taken, else if_pc+4.
- Resolution (combinational, gated by ex_valid):
  - act_taken = (op==BRANCH and ex_zero) or op==JUMP or op==JALR.
  - act_target = ex_pc_imm for BRANCH/JUMP; {ex_rs1_imm[XLEN-1:1],1'b0} for JALR.
  - mispredict = ex_valid and (act_taken != ex_pred_taken, or both taken and act_target != ex_pred_target).
  - flush = mispredict, asserted in the same cycle.
- PC update (clk rising edge):
  - mispredict: if_pc <= act_taken ? act_target : ex_pc+4. Overrides stall.
  - else if stall: hold.
  - else: if_pc <= if_pred_target.
- BTB update (clk edge; only when ex_valid, op != PLUS4, and PRED_EN=1):
  - Hit on ex_pc, BRANCH: counter saturating +1 if taken, -1 if not; limits 0 and 3.
  - Hit, JUMP/JALR: target updated, counter=3, is_jump=1.
  - Miss and act_taken: allocate/overwrite the entry (valid, tag, target, is_jump = op!=BRANCH, counter=2 for a branch or 3 for a jump).
  - Miss and not taken: no allocation.
- Same-cycle read/write to one index: lookup sees the pre-update contents; the write is visible the next cycle.
- mispredict_cnt: +1 per mispredict cycle; saturates at all-ones, no wrap.
- Address arithmetic is modulo 2^XLEN: pc+4 wraps silently.
- Reset asserted mid-operation: state clears immediately; no update is completed on that edge.

Decomposition:
- NPC_PLUS4/BRANCH/JUMP/JALR stay in the shared ctrl_encode_def.v header. Counter constants (STRONG_NT=0 ... STRONG_T=3) are added there too.
- One sub-module, npc_btb:
  - storage arrays (valid/tag/target/is_jump/ctr);
  - combinational read port for the lookup;
  - one synchronous write port with the counter update logic.
- npc_predict holds the PC register, resolution/flush logic and the statistics counter.

Test Plan:
1. Reset: hold rstn=0, release; stall=0, ex_valid=0 -> if_pc sequence 0x0, 0x4, 0x8; flush=0; mispredict_cnt=0.
2. Cold BEQ: ex_pc=0x10, op=BRANCH, zero=1, pc_imm=0x40, pred_taken=0 -> flush=1 that cycle; next if_pc=0x40; mispredict_cnt=1; entry allocated with counter=2.
3. Warm branch: fetch 0x10 again -> if_pred_taken=1, if_pred_target=0x40. Resolve taken -> flush=0; counter=3. Then resolve not-taken twice -> counter reaches 1; next fetch of 0x10 predicts 0x14.
4. JALR: rs1_imm=0x81, pred_target=0x90 -> act_target=0x80; flush=1; if_pc=0x80. Stall=1 in the same cycle still redirects.
5. Aliasing (BTB_DEPTH=16): allocate taken branches at 0x10 and 0x50 (same idx) -> the second overwrites; fetch 0x10 -> miss, predicts 0x14.
6. PRED_EN=0 and saturation (CNT_W=2): four consecutive taken branches -> every one flushes; mispredict_cnt sticks at 3.
